// File: rtl/cpu_fabric_pkg.sv
// Shared widths and state encoding for the CPU-to-fabric operation bridge.
package cpu_fabric_pkg;

  localparam int OP_W  = 4;
  localparam int RES_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/fabric_lat_counter.sv
// Loadable down-counter that times the fabric pipeline; zero_o marks the capture cycle.
module fabric_lat_counter #(
  parameter int LAT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [LAT_W-1:0] count_o,
  output logic             zero_o
);

  logic [LAT_W-1:0] count_q;
  logic [LAT_W-1:0] count_d;

  // Decrement is gated at zero so a stray dec can never wrap the count.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/cpu_fabric_bridge.sv
// Hands one 4+4-bit operation at a time to the fabric and returns the 12-bit result after cfg_latency cycles.
module cpu_fabric_bridge
  import cpu_fabric_pkg::*;
#(
  parameter int LAT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             UserCLK,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_opa,
  input  logic [OP_W-1:0]  req_opb,
  input  logic [LAT_W-1:0] cfg_latency,
  output logic [OP_W-1:0]  fab_opa,
  output logic [OP_W-1:0]  fab_opb,
  input  logic [RES_W-1:0] fab_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  state_e           state_q;
  state_e           state_d;
  logic             req_ready_q;
  logic             busy_q;
  logic             rsp_valid_q;
  logic [OP_W-1:0]  fab_opa_q;
  logic [OP_W-1:0]  fab_opb_q;
  logic [RES_W-1:0] rsp_data_q;
  logic [CNT_W-1:0] done_count_q;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [LAT_W-1:0] cnt_value;
  logic             capture;
  logic             rsp_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    r = (&v) ? v : (v + 1'b1);
    return r;
  endfunction

  fabric_lat_counter #(
    .LAT_W(LAT_W)
  ) u_lat_cnt (
    .clk_i      (UserCLK),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cfg_latency),
    .dec_i      (cnt_dec),
    .count_o    (cnt_value),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    capture  = 1'b0;
    rsp_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          cnt_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      fab_opa_q    <= '0;
      fab_opb_q    <= '0;
      rsp_data_q   <= '0;
      done_count_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      if (cnt_load) begin
        fab_opa_q <= req_opa;
        fab_opb_q <= req_opb;
      end
      if (capture) begin
        rsp_data_q <= fab_res;
      end
      if (rsp_fire) begin
        done_count_q <= sat_inc(done_count_q);
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign fab_opa    = fab_opa_q;
  assign fab_opb    = fab_opb_q;
  assign rsp_data   = rsp_data_q;
  assign done_count = done_count_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt_value;

endmodule

// File: tb/tb_cpu_fabric_bridge.sv
// Directed bench: table of operations plus reset-abort and handshake corner sequences.
module tb_cpu_fabric_bridge;

  localparam int LAT_W = 8;
  localparam int CNT_W = 2;

  logic             UserCLK = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_opa;
  logic [3:0]       req_opb;
  logic [LAT_W-1:0] cfg_latency;
  logic [3:0]       fab_opa;
  logic [3:0]       fab_opb;
  logic [11:0]      fab_res;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [11:0]      rsp_data;
  logic             busy;
  logic [CNT_W-1:0] done_count;

  int checks = 0;
  int errors = 0;

  cpu_fabric_bridge #(
    .LAT_W(LAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .UserCLK     (UserCLK),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opa     (req_opa),
    .req_opb     (req_opb),
    .cfg_latency (cfg_latency),
    .fab_opa     (fab_opa),
    .fab_opb     (fab_opb),
    .fab_res     (fab_res),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .done_count  (done_count)
  );

  always #5 UserCLK = ~UserCLK;

  typedef struct {
    logic [7:0]  lat;
    logic [7:0]  lat2;
    logic [3:0]  opa;
    logic [3:0]  opb;
    logic [11:0] res;
    int          hold;
    logic [1:0]  done_exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic early;
    logic bad;

    vecs[0] = '{lat: 8'd3,   lat2: 8'd3,  opa: 4'h5, opb: 4'hA, res: 12'hABC, hold: 0, done_exp: 2'd1};
    vecs[1] = '{lat: 8'd0,   lat2: 8'd0,  opa: 4'h1, opb: 4'h2, res: 12'h123, hold: 0, done_exp: 2'd2};
    vecs[2] = '{lat: 8'd1,   lat2: 8'd1,  opa: 4'h7, opb: 4'h3, res: 12'h5A5, hold: 5, done_exp: 2'd3};
    vecs[3] = '{lat: 8'd2,   lat2: 8'd9,  opa: 4'hC, opb: 4'h4, res: 12'h3C3, hold: 1, done_exp: 2'd3};
    vecs[4] = '{lat: 8'd255, lat2: 8'd0,  opa: 4'hF, opb: 4'hE, res: 12'hFFF, hold: 0, done_exp: 2'd3};
    vecs[5] = '{lat: 8'd7,   lat2: 8'd1,  opa: 4'h8, opb: 4'h9, res: 12'h001, hold: 2, done_exp: 2'd3};

    rst = 1'b1; req_valid = 1'b0; req_opa = 4'h0; req_opb = 4'h0;
    cfg_latency = 8'd0; fab_res = 12'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge UserCLK);
    @(negedge UserCLK);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_fab_op", {24'd0, fab_opa, fab_opb}, 32'd0);
    chk("rst_rsp_data", {20'd0, rsp_data}, 32'd0);
    chk("rst_done", {30'd0, done_count}, 32'd0);
    rst = 1'b0;
    @(negedge UserCLK);

    for (int n = 0; n < 6; n++) begin
      v = vecs[n];
      chk("idle_ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_opa = v.opa; req_opb = v.opb;
      cfg_latency = v.lat; fab_res = ~v.res;
      @(negedge UserCLK);
      req_valid = 1'b0; req_opa = ~v.opa; req_opb = ~v.opb; cfg_latency = v.lat2;
      chk("acc_fab_opa", {28'd0, fab_opa}, {28'd0, v.opa});
      chk("acc_fab_opb", {28'd0, fab_opb}, {28'd0, v.opb});
      chk("acc_busy", {31'd0, busy}, 32'd1);
      chk("acc_not_ready", {31'd0, req_ready}, 32'd0);
      early = 1'b0;
      for (int i = 0; i <= int'(v.lat); i++) begin
        if (i == int'(v.lat)) fab_res = v.res;
        @(negedge UserCLK);
        if (i < int'(v.lat) && rsp_valid) early = 1'b1;
      end
      fab_res = 12'h0F0;
      chk("no_early_valid", {31'd0, early}, 32'd0);
      chk("cap_valid", {31'd0, rsp_valid}, 32'd1);
      chk("cap_data", {20'd0, rsp_data}, {20'd0, v.res});
      bad = 1'b0;
      for (int h = 0; h < v.hold; h++) begin
        fab_res = 12'h0F0 + 12'(h); req_valid = 1'b1;
        req_opa = 4'(h); req_opb = 4'(h + 3);
        @(negedge UserCLK);
        if (!rsp_valid || rsp_data !== v.res || req_ready || fab_opa !== v.opa) bad = 1'b1;
      end
      if (v.hold > 0) chk("backpressure_hold", {31'd0, bad}, 32'd0);
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge UserCLK);
      rsp_ready = 1'b0;
      chk("rel_valid_clr", {31'd0, rsp_valid}, 32'd0);
      chk("rel_done", {30'd0, done_count}, {30'd0, v.done_exp});
      chk("rel_ready", {31'd0, req_ready}, 32'd1);
      chk("rel_opa_held", {28'd0, fab_opa}, {28'd0, v.opa});
    end

    // Reset while waiting on the fabric aborts the operation.
    req_valid = 1'b1; req_opa = 4'h9; req_opb = 4'h6; cfg_latency = 8'd4; fab_res = 12'h777;
    @(negedge UserCLK);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge UserCLK);
    chk("wrst_ready_low", {31'd0, req_ready}, 32'd0);
    chk("wrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge UserCLK);
    chk("wrst_ready", {31'd0, req_ready}, 32'd1);
    chk("wrst_fab_opa", {28'd0, fab_opa}, 32'd0);
    chk("wrst_done", {30'd0, done_count}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge UserCLK);
      if (rsp_valid || busy) bad = 1'b1;
    end
    chk("wrst_no_resp", {31'd0, bad}, 32'd0);

    // Reset while holding a response drops it.
    req_valid = 1'b1; req_opa = 4'h2; req_opb = 4'h3; cfg_latency = 8'd0; fab_res = 12'h246;
    @(negedge UserCLK);
    req_valid = 1'b0;
    @(negedge UserCLK);
    chk("rrst_valid_pre", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    @(negedge UserCLK);
    rst = 1'b0;
    @(negedge UserCLK);
    chk("rrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rrst_data", {20'd0, rsp_data}, 32'd0);
    chk("rrst_done", {30'd0, done_count}, 32'd0);
    chk("rrst_ready", {31'd0, req_ready}, 32'd1);

    // rsp_ready held high outside RESP must not count anything.
    rsp_ready = 1'b1;
    repeat (3) @(negedge UserCLK);
    chk("idle_rsp_ready_ignored", {30'd0, done_count}, 32'd0);
    req_valid = 1'b1; req_opa = 4'h4; req_opb = 4'h5; cfg_latency = 8'd1; fab_res = 12'h000;
    @(negedge UserCLK);
    req_valid = 1'b0;
    @(negedge UserCLK);
    chk("wait_rsp_ready_ignored", {31'd0, rsp_valid}, 32'd0);
    fab_res = 12'h456;
    @(negedge UserCLK);
    fab_res = 12'h000;
    chk("fin_valid", {31'd0, rsp_valid}, 32'd1);
    chk("fin_data", {20'd0, rsp_data}, 32'h456);
    @(negedge UserCLK);
    rsp_ready = 1'b0;
    chk("fin_valid_clr", {31'd0, rsp_valid}, 32'd0);
    chk("fin_done", {30'd0, done_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_fabric_bridge.md
CPU_FABRIC_BRIDGE -- requirements
Module: cpu_fabric_bridge

Interface
REQ-001 SHALL have parameter LAT_W, default 8: width of the fabric-latency counter and of cfg_latency.
REQ-002 SHALL have parameter CNT_W, default 16: width of the completed-operation counter.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port UserCLK, input, 1 bit: the single clock, shared with the fabric tiles.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1 bit: CPU operation request.
REQ-007 SHALL have port req_ready, output, 1 bit: bridge can accept a request.
REQ-008 SHALL have port req_opa, input, 4 bits: operand A.
REQ-009 SHALL have port req_opb, input, 4 bits: operand B.
REQ-010 SHALL have port cfg_latency, input, LAT_W bits: fabric pipeline depth in cycles.
REQ-011 SHALL have port fab_opa, output, 4 bits: drives the fabric OPA_I3..I0 inputs.
REQ-012 SHALL have port fab_opb, output, 4 bits: drives the fabric OPB_I3..I0 inputs.
REQ-013 SHALL have port fab_res, input, 12 bits: fabric result, where bit 4k+i = RESk_Oi.
REQ-014 SHALL have port rsp_valid, output, 1 bit: result available.
REQ-015 SHALL have port rsp_ready, input, 1 bit: CPU accepts the result.
REQ-016 SHALL have port rsp_data, output, 12 bits: captured fabric result.
REQ-017 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-018 SHALL have port done_count, output, CNT_W bits: number of completed operations.

Function
REQ-019 SHALL implement exactly three states, IDLE, WAIT and RESP, with req_ready = 1 only in IDLE.
REQ-020 SHALL treat req_valid && req_ready in cycle t as an accept: register req_opa and req_opb onto fab_opa and fab_opb (visible from t+1), load the counter with cfg_latency, and go to WAIT.
REQ-021 SHALL hold fab_opa and fab_opb stable from one accept until the next accept.
REQ-022 SHALL, in WAIT, capture fab_res into rsp_data when the counter equals 0, set rsp_valid and go to RESP; otherwise the counter SHALL decrement by 1.
REQ-023 SHALL give the following latency: accept at t -> capture at edge t+1+L -> rsp_valid high at t+1+L, where L = cfg_latency sampled at accept.
REQ-024 SHALL treat L = 0 as valid, with capture in the first WAIT cycle.
REQ-025 SHALL ignore changes to cfg_latency after accept until the next accept.
REQ-026 SHALL, in RESP, hold rsp_valid and rsp_data stable until rsp_ready = 1; on that cycle it SHALL clear rsp_valid, increment done_count and return to IDLE.
REQ-027 SHALL leave one IDLE bubble between back-to-back operations, giving a peak rate of one operation per L+3 cycles.
REQ-028 SHALL saturate done_count at all-ones, with no wrap-around.
REQ-029 SHALL ignore rsp_ready outside RESP, and SHALL not accept req_valid outside IDLE.
REQ-030 SHALL treat cfg_latency = 2^LAT_W-1 as legal, with no counter underflow.

Reset
REQ-031 SHALL, while rst = 1 at a clock edge, take state to IDLE and force fab_opa, fab_opb, rsp_data, counter and done_count to 0, rsp_valid to 0, busy to 0, and req_ready to 0 during reset.
REQ-032 SHALL, on reset mid-WAIT or mid-RESP, abort the operation: no response and no done_count increment; req_ready SHALL be 1 in the first cycle after rst falls.

Structure
REQ-033 SHALL place OP_W = 4, RES_W = 12 and the state enum type in the shared package cpu_fabric_pkg.
REQ-034 SHALL implement the loadable down-counter with zero flag as sub-module fabric_lat_counter, parameterised by LAT_W.
REQ-035 SHALL register all outputs; fab_res SHALL be the only input sampled combinationally into the capture register.

Verification
REQ-036 SHALL cover a basic operation: cfg_latency = 3, accept opa = 0x5, opb = 0xA at t; fabric model returns 0xABC at t+4 -> rsp_valid at t+4, rsp_data = 0xABC, done_count = 1.
REQ-037 SHALL cover zero latency: cfg_latency = 0, fab_res = 0x123 -> rsp_valid at t+1, rsp_data = 0x123.
REQ-038 SHALL cover backpressure: rsp_ready low for 5 cycles in RESP while fab_res changes -> rsp_data stays constant, req_ready = 0, second req_valid not accepted.
REQ-039 SHALL cover a latency change mid-operation: accept with cfg_latency = 2, then change it to 9 -> capture still at t+3.
REQ-040 SHALL cover reset in WAIT: rst pulsed at t+1 with cfg_latency = 4 -> no rsp_valid, fab_opa = 0, done_count = 0, req_ready = 1 at the cycle after rst falls.
REQ-041 SHALL cover saturation: CNT_W = 2, 5 completed operations -> done_count = 3.
